proc_io_bridge: RTL

PROC_IO_BRIDGE -- requirements
Module: proc_io_bridge

---
 rtl/proc_io_pkg.sv | 13 +
 rtl/proc_io_bridge_slot.sv | 36 +++
 rtl/proc_io_bridge.sv | 132 +++++++++++++
 3 files changed

// File: rtl/proc_io_pkg.sv
// Shared defaults and helpers for the processor I/O bridge.
package proc_io_pkg;

  localparam int DEF_NUBITS = 16;
  localparam int DEF_NUIOIN = 8;
  localparam int DEF_NUIOOU = 8;

  // Channel-address width; a single channel still gets a 1-bit address port.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/proc_io_bridge_slot.sv
// io_slot: one-entry register with a full bit and a valid/ready handshake on each side.
module io_slot #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         full;
  logic [W-1:0] data;

  assign in_ready  = ~full;
  assign out_valid = full;
  assign out_data  = data;

  // NOTE: the data register is reset too; it is a single word, and a stale read of an
  // empty input channel must return a defined value right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && !full) begin
      data <= in_data;
      full <= 1'b1;
    end else if (out_ready && full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/proc_io_bridge.sv
// Processor <-> channel I/O bridge with one-entry buffers per channel.
// Macro IO_BRIDGE_BLOCK_EN selects blocking (stall) mode; default is non-blocking with sticky ovf/udf.
module proc_io_bridge
  import proc_io_pkg::*;
#(
  parameter int NUBITS = DEF_NUBITS,
  parameter int NUIOIN = DEF_NUIOIN,
  parameter int NUIOOU = DEF_NUIOOU
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUBITS-1:0]          io_out,
  input  logic [addr_w(NUIOOU)-1:0]  addr_out,
  input  logic                       out_en,
  input  logic                       req_in,
  input  logic [addr_w(NUIOIN)-1:0]  addr_in,
  output logic [NUBITS-1:0]          io_in,
  output logic                       stall,
  input  logic [NUIOIN*NUBITS-1:0]   ch_in_data,
  input  logic [NUIOIN-1:0]          ch_in_valid,
  output logic [NUIOIN-1:0]          ch_in_ready,
  output logic [NUIOOU*NUBITS-1:0]   ch_out_data,
  output logic [NUIOOU-1:0]          ch_out_valid,
  input  logic [NUIOOU-1:0]          ch_out_ready,
  output logic [NUIOOU-1:0]          ovf,
  output logic [NUIOIN-1:0]          udf,
  input  logic                       clr_flags
);

  localparam int AIW = addr_w(NUIOIN);
  localparam int AOW = addr_w(NUIOOU);

  logic [NUIOIN-1:0] in_full;
  logic [NUIOOU-1:0] out_full;
  logic [NUBITS-1:0] in_data [NUIOIN];
  logic [NUIOIN-1:0] rd_sel;
  logic [NUIOOU-1:0] wr_sel;

  logic rd_in_range, wr_in_range;
  logic rd_block, wr_block;
  logic rd_go, wr_go;

  assign rd_in_range = (int'(addr_in) < NUIOIN);
  assign wr_in_range = (int'(addr_out) < NUIOOU);

  // Out-of-range addresses never block: reads return 0, writes vanish.
  assign rd_block = req_in && rd_in_range && !in_full[addr_in];
  assign wr_block = out_en && wr_in_range && out_full[addr_out];

`ifdef IO_BRIDGE_BLOCK_EN
  assign stall = rd_block | wr_block;
`else
  assign stall = 1'b0;
`endif

  // A stall holds back both strobes, so a paired read/write completes together or not at all.
  assign rd_go = req_in && !stall;
  assign wr_go = out_en && !stall;

  genvar gi;
  generate
    for (gi = 0; gi < NUIOIN; gi++) begin : g_in
      logic slot_valid;

      assign rd_sel[gi]     = rd_go && rd_in_range && (addr_in == AIW'(gi));
      assign in_full[gi]    = slot_valid;

      io_slot #(.W(NUBITS)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ch_in_valid[gi]),
        .in_ready  (ch_in_ready[gi]),
        .in_data   (ch_in_data[gi*NUBITS +: NUBITS]),
        .out_valid (slot_valid),
        .out_ready (rd_sel[gi]),
        .out_data  (in_data[gi])
      );
    end

    for (gi = 0; gi < NUIOOU; gi++) begin : g_out
      logic slot_ready;

      assign wr_sel[gi]       = wr_go && wr_in_range && (addr_out == AOW'(gi));
      assign out_full[gi]     = ~slot_ready;

      // A full slot refuses the write even if it drains this same cycle.
      io_slot #(.W(NUBITS)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (wr_sel[gi]),
        .in_ready  (slot_ready),
        .in_data   (io_out),
        .out_valid (ch_out_valid[gi]),
        .out_ready (ch_out_ready[gi]),
        .out_data  (ch_out_data[gi*NUBITS +: NUBITS])
      );
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_in <= '0;
    end else if (rd_go) begin
      io_in <= rd_in_range ? in_data[addr_in] : '0;
    end
  end

`ifdef IO_BRIDGE_BLOCK_EN
  assign ovf = '0;
  assign udf = '0;
`else
  logic [NUIOOU-1:0] ovf_set;
  logic [NUIOIN-1:0] udf_set;

  assign ovf_set = wr_sel & out_full;
  assign udf_set = rd_sel & ~in_full;

  // Set wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= '0;
      udf <= '0;
    end else begin
      ovf <= (ovf & ~{NUIOOU{clr_flags}}) | ovf_set;
      udf <= (udf & ~{NUIOIN{clr_flags}}) | udf_set;
    end
  end
`endif

endmodule
